// File: rtl/stack_pkg.sv
// Shared constants and request/operation types for the EX-stage stack issue path.
package stack_pkg;
  localparam int STACK_DEPTH = 1024;
  localparam int STACK_DW    = 32;

  typedef struct packed {
    logic                push;
    logic                pop;
    logic [STACK_DW-1:0] wdata;
  } stack_req_t;

  // Pair classification after same-slot conflicts are removed
  typedef enum logic [2:0] {NONE, PUSH1, POP1, PUSH2, POP2, FWD, REPL} stack_op_e;
endpackage

// File: rtl/stack_issue_ctrl_if.sv
// ID-stage requests and stack-memory port bundle; master is the ID/stack side, slave is the controller.
interface stack_issue_ctrl_if #(
  parameter int DW = stack_pkg::STACK_DW
);
  logic          id_vld0, id_vld1;
  logic          id_push0, id_pop0, id_push1, id_pop1;
  logic [DW-1:0] id_wdata0, id_wdata1;
  logic          push0, pop0, push1, pop1;
  logic [DW-1:0] wdata0, wdata1;
  logic [DW-1:0] stack0_EX_DM, stack1_EX_DM;

  modport master (
    output id_vld0, id_vld1, id_push0, id_pop0, id_push1, id_pop1, id_wdata0, id_wdata1,
    output stack0_EX_DM, stack1_EX_DM,
    input  push0, pop0, push1, pop1, wdata0, wdata1
  );

  modport slave (
    input  id_vld0, id_vld1, id_push0, id_pop0, id_push1, id_pop1, id_wdata0, id_wdata1,
    input  stack0_EX_DM, stack1_EX_DM,
    output push0, pop0, push1, pop1, wdata0, wdata1
  );
endinterface

// File: rtl/stack_legalize.sv
// Combinational legality check of one instruction pair against the shadow stack depth.
module stack_legalize
  import stack_pkg::*;
#(
  parameter int DEPTH = STACK_DEPTH,
  parameter int AW    = $clog2(DEPTH) + 1
) (
  input  logic          push0,
  input  logic          pop0,
  input  logic          push1,
  input  logic          pop1,
  input  logic [AW-1:0] depth,
  output logic          lpush0,
  output logic          lpop0,
  output logic          lpush1,
  output logic          lpop1,
  output logic [1:0]    inc,
  output logic [1:0]    dec,
  output logic          ovf,
  output logic          unf,
  output logic          ill
);
  logic      a0push, a0pop, a1push, a1pop;
  logic      full, almost, empty, one;
  stack_op_e op;

  // A slot asking for both push and pop is killed outright
  assign a0push = push0 & ~pop0;
  assign a0pop  = pop0 & ~push0;
  assign a1push = push1 & ~pop1;
  assign a1pop  = pop1 & ~push1;

  assign full   = depth == AW'(DEPTH);
  assign almost = depth == AW'(DEPTH - 1);
  assign empty  = depth == '0;
  assign one    = depth == AW'(1);

  always_comb begin
    op = NONE;
    if (a0push & a1push)      op = PUSH2;
    else if (a0pop & a1pop)   op = POP2;
    else if (a0push & a1pop)  op = FWD;
    else if (a0pop & a1push)  op = REPL;
    else if (a0push | a1push) op = PUSH1;
    else if (a0pop | a1pop)   op = POP1;
  end

  always_comb begin
    lpush0 = a0push;
    lpop0  = a0pop;
    lpush1 = a1push;
    lpop1  = a1pop;
    inc    = 2'd0;
    dec    = 2'd0;
    ovf    = 1'b0;
    unf    = 1'b0;
    ill    = (push0 & pop0) | (push1 & pop1);
    case (op)
      PUSH1: if (full) begin lpush0 = 1'b0; lpush1 = 1'b0; ovf = 1'b1; end
             else inc = 2'd1;
      POP1:  if (empty) begin lpop0 = 1'b0; lpop1 = 1'b0; unf = 1'b1; end
             else dec = 2'd1;
      PUSH2: if (full) begin lpush0 = 1'b0; lpush1 = 1'b0; ovf = 1'b1; end
             else if (almost) begin lpush1 = 1'b0; ovf = 1'b1; inc = 2'd1; end
             else inc = 2'd2;
      POP2:  if (empty) begin lpop0 = 1'b0; lpop1 = 1'b0; unf = 1'b1; end
             else if (one) begin lpop1 = 1'b0; unf = 1'b1; dec = 2'd1; end
             else dec = 2'd2;
      // Empty stack: pop0 has nothing to return, push1 still lands
      REPL:  if (empty) begin lpop0 = 1'b0; unf = 1'b1; inc = 2'd1; end
      default: ;
    endcase
  end
endmodule

// File: rtl/stack_issue_ctrl.sv
// EX-stage issue controller: registers ID stack requests, legalises them and drives the stack once per pair.
module stack_issue_ctrl
  import stack_pkg::*;
#(
  parameter int DEPTH = STACK_DEPTH,
  parameter int DW    = STACK_DW,
  parameter int AW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  stack_issue_ctrl_if.slave bus,
  output logic [DW-1:0]     pop_data0,
  output logic [DW-1:0]     pop_data1,
  output logic              pop_vld0,
  output logic              pop_vld1,
  output logic [AW-1:0]     depth,
  output logic              ovf_err,
  output logic              unf_err,
  output logic              ill_err
);
  stack_req_t ex0, ex1;
  logic       issued, act;
  logic       pop0_d1, pop1_d1;
  logic       lpush0, lpop0, lpush1, lpop1, ovf, unf, ill;
  logic [1:0] inc, dec;

  stack_legalize #(.DEPTH(DEPTH), .AW(AW)) u_legal (
    .push0 (ex0.push), .pop0 (ex0.pop), .push1 (ex1.push), .pop1 (ex1.pop),
    .depth (depth),
    .lpush0(lpush0), .lpop0(lpop0), .lpush1(lpush1), .lpop1(lpop1),
    .inc   (inc), .dec(dec), .ovf(ovf), .unf(unf), .ill(ill)
  );

  assign act = ex0.push | ex0.pop | ex1.push | ex1.pop;

  // Driven only from flops, so a stalled pair cannot re-issue once issued is set
  assign bus.push0  = lpush0 & ~issued;
  assign bus.pop0   = lpop0 & ~issued;
  assign bus.push1  = lpush1 & ~issued;
  assign bus.pop1   = lpop1 & ~issued;
  assign bus.wdata0 = ex0.wdata;
  assign bus.wdata1 = ex1.wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex0       <= '0;
      ex1       <= '0;
      issued    <= 1'b0;
      depth     <= '0;
      ovf_err   <= 1'b0;
      unf_err   <= 1'b0;
      ill_err   <= 1'b0;
      pop0_d1   <= 1'b0;
      pop1_d1   <= 1'b0;
      pop_vld0  <= 1'b0;
      pop_vld1  <= 1'b0;
      pop_data0 <= '0;
      pop_data1 <= '0;
    end else begin
      if (flush) begin
        ex0.push <= 1'b0;
        ex0.pop  <= 1'b0;
        ex1.push <= 1'b0;
        ex1.pop  <= 1'b0;
        issued   <= 1'b0;
      end else if (!stall) begin
        ex0    <= '{push: bus.id_push0 & bus.id_vld0, pop: bus.id_pop0 & bus.id_vld0,
                    wdata: bus.id_wdata0};
        ex1    <= '{push: bus.id_push1 & bus.id_vld1, pop: bus.id_pop1 & bus.id_vld1,
                    wdata: bus.id_wdata1};
        issued <= 1'b0;
      end else if (act) begin
        issued <= 1'b1;
      end

      if (!issued) begin
        depth   <= depth + AW'(inc) - AW'(dec);
        ovf_err <= ovf_err | ovf;
        unf_err <= unf_err | unf;
        ill_err <= ill_err | ill;
      end

      // Stack read data is flopped, so capture one cycle after the pop fires
      pop0_d1  <= bus.pop0;
      pop1_d1  <= bus.pop1;
      pop_vld0 <= pop0_d1;
      pop_vld1 <= pop1_d1;
      if (pop0_d1) pop_data0 <= bus.stack0_EX_DM;
      if (pop1_d1) pop_data1 <= bus.stack1_EX_DM;
    end
  end
endmodule

// File: tb/tb_stack_issue_ctrl.sv
// Directed bench for stack_issue_ctrl with a behavioural dual-port stack and a pop-result scoreboard.
module tb_stack_issue_ctrl;
  import stack_pkg::*;

  localparam int DEPTH = 1024;
  localparam int DW    = 32;
  localparam int AW    = 11;

  logic          clk = 1'b0;
  logic          rst, stall, flush;
  logic [DW-1:0] pop_data0, pop_data1;
  logic          pop_vld0, pop_vld1;
  logic [AW-1:0] depth;
  logic          ovf_err, unf_err, ill_err;

  stack_issue_ctrl_if #(.DW(DW)) bus ();

  stack_issue_ctrl #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .flush    (flush),
    .bus      (bus),
    .pop_data0(pop_data0),
    .pop_data1(pop_data1),
    .pop_vld0 (pop_vld0),
    .pop_vld1 (pop_vld1),
    .depth    (depth),
    .ovf_err  (ovf_err),
    .unf_err  (unf_err),
    .ill_err  (ill_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural stack: slot0 acts before slot1; push0&pop1 forwards wdata0
  logic [DW-1:0] mem [DEPTH];
  int sp = 0;
  always @(posedge clk) begin
    if (rst) begin
      sp               <= 0;
      bus.stack0_EX_DM <= '0;
      bus.stack1_EX_DM <= '0;
    end else begin
      if (bus.push0) mem[sp] <= bus.wdata0;
      if (bus.push1) mem[sp + int'(bus.push0) - int'(bus.pop0)] <= bus.wdata1;
      if (bus.pop0) bus.stack0_EX_DM <= mem[sp - 1];
      if (bus.pop1) bus.stack1_EX_DM <= bus.push0 ? bus.wdata0 : mem[sp - 1 - int'(bus.pop0)];
      sp <= sp + int'(bus.push0) + int'(bus.push1) - int'(bus.pop0) - int'(bus.pop1);
    end
  end

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   n_push0 = 0;
  int   n_act = 0;
  int   n0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: counts stack strobes and retires pop results against the scoreboard
  initial forever begin
    exp_t e;
    @(negedge clk);
    n_push0 += int'(bus.push0);
    n_act   += int'(bus.push0) + int'(bus.pop0) + int'(bus.push1) + int'(bus.pop1);
    if (pop_vld0) begin
      if (q0.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL pop0_unexpected: got pop_vld0 with data 0x%0h, expected none", pop_data0);
      end else begin
        e = q0.pop_front();
        chk("pop_data0", pop_data0, e.data);
        chk("pop_vld0_cycle", cyc, e.cyc);
      end
    end
    if (pop_vld1) begin
      if (q1.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL pop1_unexpected: got pop_vld1 with data 0x%0h, expected none", pop_data1);
      end else begin
        e = q1.pop_front();
        chk("pop_data1", pop_data1, e.data);
        chk("pop_vld1_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic clr_id();
    bus.id_vld0 = 1'b0; bus.id_push0 = 1'b0; bus.id_pop0 = 1'b0; bus.id_wdata0 = '0;
    bus.id_vld1 = 1'b0; bus.id_push1 = 1'b0; bus.id_pop1 = 1'b0; bus.id_wdata1 = '0;
  endtask

  // One ID pair per cycle; expected pop results appear 3 negedges after being driven
  task automatic pair(input logic pu0, input logic po0, input logic [DW-1:0] w0,
                      input logic pu1, input logic po1, input logic [DW-1:0] w1,
                      input logic e0, input logic [DW-1:0] x0,
                      input logic e1, input logic [DW-1:0] x1);
    exp_t e;
    @(negedge clk);
    bus.id_vld0 = pu0 | po0; bus.id_push0 = pu0; bus.id_pop0 = po0; bus.id_wdata0 = w0;
    bus.id_vld1 = pu1 | po1; bus.id_push1 = pu1; bus.id_pop1 = po1; bus.id_wdata1 = w1;
    if (e0) begin e.data = x0; e.cyc = cyc + 3; q0.push_back(e); end
    if (e1) begin e.data = x1; e.cyc = cyc + 3; q1.push_back(e); end
  endtask

  task automatic idle(input int n);
    repeat (n) pair(0, 0, '0, 0, 0, '0, 0, '0, 0, '0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_depth"}, depth, 0);
    chk({tag, "_errs"}, {ovf_err, unf_err, ill_err}, 0);
    chk({tag, "_pop_vld"}, {pop_vld0, pop_vld1}, 0);
    chk({tag, "_pop_data0"}, pop_data0, 0);
    chk({tag, "_pop_data1"}, pop_data1, 0);
    chk({tag, "_ctrl"}, {bus.push0, bus.pop0, bus.push1, bus.pop1}, 0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    clr_id();
    repeat (2) @(negedge clk);
    chk_quiet("reset");
    rst = 1'b0;

    // push then pop back-to-back
    pair(1, 0, 32'hAAAA0001, 0, 0, '0, 0, '0, 0, '0);
    pair(0, 1, '0, 0, 0, '0, 1, 32'hAAAA0001, 0, '0);
    idle(3);
    chk("t1_depth", depth, 0);

    // pair push then pair pop: LIFO order across slots
    pair(1, 0, 32'h11, 1, 0, 32'h22, 0, '0, 0, '0);
    idle(2);
    chk("t2_depth_after_push", depth, 2);
    pair(0, 1, '0, 0, 1, '0, 1, 32'h22, 1, 32'h11);
    idle(3);
    chk("t2_depth_after_pop", depth, 0);

    // push0&pop1 forwarding at depth 0
    pair(1, 0, 32'h77, 0, 1, '0, 0, '0, 1, 32'h77);
    idle(3);
    chk("t3_depth", depth, 0);
    chk("t3_errs", {ovf_err, unf_err, ill_err}, 0);

    // stalled push must issue exactly once
    n0 = n_push0;
    pair(1, 0, 32'h5, 0, 0, '0, 0, '0, 0, '0);
    @(negedge clk);
    clr_id();
    stall = 1'b1;
    repeat (3) @(negedge clk);
    stall = 1'b0;
    idle(3);
    chk("t4_push0_strobes", n_push0 - n0, 1);
    chk("t4_depth", depth, 1);
    pair(0, 1, '0, 0, 0, '0, 1, 32'h5, 0, '0);
    idle(3);
    chk("t4_depth_after_pop", depth, 0);

    // pair pop at depth 1: pop1 dropped
    pair(1, 0, 32'h33, 0, 0, '0, 0, '0, 0, '0);
    pair(0, 1, '0, 0, 1, '0, 1, 32'h33, 0, '0);
    idle(3);
    chk("t5_unf_err", unf_err, 1);
    chk("t5_depth", depth, 0);
    chk("t5_ovf_err", ovf_err, 0);

    // invalid slot and flushed pair never reach the stack
    n0 = n_act;
    @(negedge clk);
    clr_id();
    bus.id_push0 = 1'b1; bus.id_wdata0 = 32'hDEAD;
    @(negedge clk);
    bus.id_vld0 = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    clr_id();
    idle(3);
    chk("t6_activity", n_act - n0, 0);
    chk("t6_depth", depth, 0);

    // fill to DEPTH-1, then pair push overflows on slot1
    for (int i = 0; i < 511; i++) pair(1, 0, 32'(2 * i), 1, 0, 32'(2 * i + 1), 0, '0, 0, '0);
    pair(1, 0, 32'h3FE, 0, 0, '0, 0, '0, 0, '0);
    idle(2);
    chk("t7_depth_almost_full", depth, 1023);
    pair(1, 0, 32'hB0, 1, 0, 32'hB1, 0, '0, 0, '0);
    idle(2);
    chk("t7_depth_full", depth, 1024);
    chk("t7_ovf_err", ovf_err, 1);
    pair(0, 1, '0, 0, 0, '0, 1, 32'hB0, 0, '0);
    idle(3);
    chk("t7_depth_after_pop", depth, 1023);

    // same-slot push&pop is illegal and silent
    n0 = n_act;
    pair(1, 1, 32'hEE, 0, 0, '0, 0, '0, 0, '0);
    idle(3);
    chk("t8_ill_err", ill_err, 1);
    chk("t8_activity", n_act - n0, 0);
    chk("t8_depth", depth, 1023);

    // one-cycle reset clears everything
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_quiet("rerst");
    rst = 1'b0;

    idle(3);
    chk("q0_leftover", q0.size(), 0);
    chk("q1_leftover", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/stack_issue_ctrl.md
Name: stack_issue_ctrl

Overview:
- Sits in the EX stage between dual-issue decode and the 32x1024 dual-port push/pop stack.
- Registers each instruction pair's push/pop requests from ID and legality-checks them against a shadow depth counter.
- Drives the stack's push0/push1/pop0/pop1/wdata0/wdata1 exactly once per instruction pair, including across pipeline stalls.
- Captures the stack's flopped read results (stack0_EX_DM/stack1_EX_DM) into held pop-data registers for the consumer stage.

Parameters:
- DEPTH, 1024, stack entries; must match the stack memory.
- DW, 32, data width.
- AW, 11, depth counter width ($clog2(DEPTH)+1), so DEPTH itself is representable.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- stall  in  1  pipeline stall; holds the EX register
- flush  in  1  kill the EX-bound pair (branch mispredict)
- id_vld0 / id_vld1  in  1  slot0 / slot1 instruction valid in ID
- id_push0 / id_pop0  in  1  slot0 stack request
- id_push1 / id_pop1  in  1  slot1 stack request
- id_wdata0 / id_wdata1  in  DW  push data
- push0 / pop0 / push1 / pop1  out  1  stack controls
- wdata0 / wdata1  out  DW  stack write data
- stack0_EX_DM / stack1_EX_DM  in  DW  flopped stack read data
- pop_data0 / pop_data1  out  DW  held pop results
- pop_vld0 / pop_vld1  out  1  one-cycle strobe: pop_data updated this cycle
- depth  out  AW  shadow occupancy
- ovf_err / unf_err / ill_err  out  1  sticky error flags

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: EX register invalid, issued=0, depth=0, all errors=0, pop_data*=0, pop_vld*=0, all stack controls=0.
- EX register load:
  - When ~stall: EX register <= ID fields, with each slot's request bits ANDed with id_vldN.
  - When flush (takes priority over stall): request bits cleared.
  - When stall: EX register held.
- Issued flag:
  - Set at the clock edge ending a cycle in which the EX pair fired while stall=1.
  - Cleared whenever the EX register reloads.
- Outputs: pushN/popN = legalised EX bits & ~issued. Outputs are combinational from flops only, so each push/pop reaches the stack exactly once.
- Legalisation (computed from EX bits and current depth):
  - Same-slot push&pop: drop both of that slot's bits, set ill_err.
  - push0&pop1: legal at any depth (stack forwards wdata0); depth unchanged.
  - pop0&push1: at depth 0, drop pop0 and set unf_err; push1 proceeds and depth += 1. Otherwise depth unchanged.
  - push0&push1: depth <= DEPTH-2 → depth += 2. depth = DEPTH-1 → drop push1, set ovf_err, depth += 1. depth = DEPTH → drop both, set ovf_err.
  - pop0&pop1: depth >= 2 → depth -= 2. depth = 1 → drop pop1, set unf_err, depth -= 1. depth = 0 → drop both, set unf_err.
  - Single push at depth = DEPTH: dropped, ovf_err set.
  - Single pop at depth = 0: dropped, unf_err set.
- Depth update: applied in the firing cycle only, never while issued=1.
- Pop capture:
  - Fire cycle T with legal popN → popN_d1 registered.
  - In cycle T+1, pop_dataN <= stackN_EX_DM and pop_vldN is asserted for one cycle.
  - Capture happens regardless of stall in T+1.
  - For push0&pop1 the stack returns wdata0 on slot1, so pop_data1 = wdata0.
- Error flags: sticky until rst.
- Reset mid-operation: pending pop captures are discarded and depth returns to 0. The stack has its own reset and must be reset in the same cycle.

Decomposition:
- Shared package stack_pkg holds:
  - STACK_DEPTH and STACK_DW constants.
  - typedef stack_req_t {push, pop, wdata}.
  - enum stack_op_e: NONE, PUSH1, POP1, PUSH2, POP2, FWD, REPL.
- Sub-module stack_legalize: purely combinational; maps (req0, req1, depth) → (legal bits, delta, err bits).

Test Plan:
- push0 wdata0=0xAAAA0001, then pop0 next pair → pop_vld0 two cycles after the pop fires; pop_data0=0xAAAA0001; depth 1→0.
- push0&push1 (0x11, 0x22), then pop0&pop1 → pop_data0=0x22, pop_data1=0x11; depth 0→2→0.
- push0 (0x5) with stall held 3 cycles → push0 high exactly one cycle; depth=1, not 4.
- push0&pop1 wdata0=0x77 at depth 0 → pop_data1=0x77; depth stays 0; no errors.
- Pair pops at depth 1 → pop1 dropped; unf_err=1; depth=0. Fill to DEPTH-1 then push0&push1 → push1 dropped; ovf_err=1; depth=1024.
- Slot0 push&pop together → no stack activity; ill_err=1. Then assert rst for one cycle → all flags cleared; depth=0; outputs 0.
